lcd_physical: RTL and testbench

- Physical layer of the character-LCD stack. Sits directly downstream of the transaction layer and drives the panel pins.
- Runs the HD44780 4-bit power-on initialisation sequence.
- Then serialises each accepted byte into two nibble writes, each with correct setup, enable-pulse and settle timing.
- Provides level and pulse handshakes back to the transaction layer.

---
 rtl/lcd_phy_pkg.sv | 35 +++
 rtl/lcd_physical.sv | 187 ++++++++++++++++++
 tb/tb_lcd_physical.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_phy_pkg.sv
// Shared types and constants for the character-LCD physical layer.
package lcd_phy_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_INIT_SETUP,
        S_INIT_PULSE,
        S_INIT_GAP,
        S_READY,
        S_HI_SETUP,
        S_HI_PULSE,
        S_HI_GAP,
        S_LO_SETUP,
        S_LO_PULSE,
        S_CMD_WAIT
    } lcd_state_e;

    // HD44780 wake-up nibbles: three "8-bit mode" writes, then the switch to 4-bit.
    localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Clear and home are the only commands that need the long post-byte wait.
    function automatic logic is_slow_cmd(input logic [7:0] b, input logic rs);
        return !rs && (b == OP_CLEAR || b == OP_HOME);
    endfunction

endpackage

// File: rtl/lcd_physical.sv
// HD44780 4-bit physical layer: power-on init sequence, then byte-to-nibble serialisation.
// Optional macro LCD_CLEAR_WAIT_EN stretches the post-byte wait for clear/home to T_CLEAR.
module lcd_physical
    import lcd_phy_pkg::*;
#(
    parameter int unsigned T_PWRUP   = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_NIB_GAP = 50,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_PULSE   = 12,
    parameter int unsigned T_CLEAR   = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       do_init,
    input  logic       do_send_data,
    input  logic [7:0] data_to_send,
    input  logic       lcdrs_in,
    output logic       init_done,
    output logic       send_data_done,
    output logic       lcde,
    output logic       lcdrs,
    output logic       lcdrw,
    output logic [3:0] lcddat
);

    localparam int unsigned T_MAX = max2(max2(max2(T_PWRUP, T_INIT1), max2(T_INIT2, T_CMD)),
                                         max2(max2(T_NIB_GAP, T_SETUP), max2(T_PULSE, T_CLEAR)));
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    // Each state is entered with (length - 1) and left when the count hits zero.
    localparam cnt_t LD_PWRUP   = cnt_t'(T_PWRUP - 1);
    localparam cnt_t LD_INIT1   = cnt_t'(T_INIT1 - 1);
    localparam cnt_t LD_INIT2   = cnt_t'(T_INIT2 - 1);
    localparam cnt_t LD_CMD     = cnt_t'(T_CMD - 1);
    localparam cnt_t LD_NIB_GAP = cnt_t'(T_NIB_GAP - 1);
    localparam cnt_t LD_SETUP   = cnt_t'(T_SETUP - 1);
    localparam cnt_t LD_PULSE   = cnt_t'(T_PULSE - 1);
    localparam cnt_t LD_CLEAR   = cnt_t'(T_CLEAR - 1);

    lcd_state_e state;
    cnt_t       cnt;
    cnt_t       init_gap;
    logic [1:0] nib_idx;
    logic [3:0] lo_nib;
    logic       slow_q;
    logic       slow_cmd;

    assign lcdrw = 1'b0;

`ifdef LCD_CLEAR_WAIT_EN
    assign slow_cmd = is_slow_cmd(data_to_send, lcdrs_in);
`else
    assign slow_cmd = 1'b0;
`endif

    always_comb begin
        init_gap = LD_CMD;
        case (nib_idx)
            2'd0:    init_gap = LD_INIT1;
            2'd1:    init_gap = LD_INIT2;
            default: init_gap = LD_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            nib_idx        <= 2'd0;
            lo_nib         <= 4'h0;
            slow_q         <= 1'b0;
            init_done      <= 1'b0;
            send_data_done <= 1'b0;
            lcde           <= 1'b0;
            lcdrs          <= 1'b0;
            lcddat         <= 4'h0;
        end else begin
            send_data_done <= 1'b0;
            if (cnt != '0) cnt <= cnt - cnt_t'(1);

            case (state)
                S_IDLE: begin
                    if (do_init) begin
                        state <= S_PWR_WAIT;
                        cnt   <= LD_PWRUP;
                    end
                end
                S_PWR_WAIT: begin
                    if (cnt == '0) begin
                        state  <= S_INIT_SETUP;
                        cnt    <= LD_SETUP;
                        lcddat <= INIT_NIB_8BIT;
                    end
                end
                S_INIT_SETUP: begin
                    if (cnt == '0) begin
                        state <= S_INIT_PULSE;
                        cnt   <= LD_PULSE;
                        lcde  <= 1'b1;
                    end
                end
                S_INIT_PULSE: begin
                    if (cnt == '0) begin
                        state <= S_INIT_GAP;
                        cnt   <= init_gap;
                        lcde  <= 1'b0;
                    end
                end
                S_INIT_GAP: begin
                    if (cnt == '0) begin
                        // nib_idx wraps back to 0 after the fourth nibble
                        nib_idx <= nib_idx + 2'd1;
                        if (nib_idx == 2'd3) begin
                            state     <= S_READY;
                            init_done <= 1'b1;
                            lcddat    <= 4'h0;
                        end else begin
                            state  <= S_INIT_SETUP;
                            cnt    <= LD_SETUP;
                            lcddat <= (nib_idx == 2'd2) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
                        end
                    end
                end
                S_READY: begin
                    if (do_send_data) begin
                        state  <= S_HI_SETUP;
                        cnt    <= LD_SETUP;
                        lcddat <= data_to_send[7:4];
                        lcdrs  <= lcdrs_in;
                        lo_nib <= data_to_send[3:0];
                        slow_q <= slow_cmd;
                    end
                end
                S_HI_SETUP: begin
                    if (cnt == '0) begin
                        state <= S_HI_PULSE;
                        cnt   <= LD_PULSE;
                        lcde  <= 1'b1;
                    end
                end
                S_HI_PULSE: begin
                    if (cnt == '0) begin
                        state <= S_HI_GAP;
                        cnt   <= LD_NIB_GAP;
                        lcde  <= 1'b0;
                    end
                end
                S_HI_GAP: begin
                    if (cnt == '0) begin
                        state  <= S_LO_SETUP;
                        cnt    <= LD_SETUP;
                        lcddat <= lo_nib;
                    end
                end
                S_LO_SETUP: begin
                    if (cnt == '0) begin
                        state <= S_LO_PULSE;
                        cnt   <= LD_PULSE;
                        lcde  <= 1'b1;
                    end
                end
                S_LO_PULSE: begin
                    if (cnt == '0) begin
                        state <= S_CMD_WAIT;
                        cnt   <= slow_q ? LD_CLEAR : LD_CMD;
                        lcde  <= 1'b0;
                    end
                end
                S_CMD_WAIT: begin
                    if (cnt == '0) begin
                        state          <= S_READY;
                        send_data_done <= 1'b1;
                        lcddat         <= 4'h0;
                        lcdrs          <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_physical.sv
// Bench for lcd_physical: observed enable pulses and done pulses are compared against
// an event-list model computed from the protocol timing rules.
module tb_lcd_physical;

    localparam int unsigned T_PWRUP   = 20;
    localparam int unsigned T_INIT1   = 10;
    localparam int unsigned T_INIT2   = 6;
    localparam int unsigned T_CMD     = 5;
    localparam int unsigned T_NIB_GAP = 3;
    localparam int unsigned T_SETUP   = 2;
    localparam int unsigned T_PULSE   = 4;
    localparam int unsigned T_CLEAR   = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       do_init = 1'b0;
    logic       do_send_data = 1'b0;
    logic [7:0] data_to_send = 8'h00;
    logic       lcdrs_in = 1'b0;
    logic       init_done, send_data_done, lcde, lcdrs, lcdrw;
    logic [3:0] lcddat;

    lcd_physical #(
        .T_PWRUP  (T_PWRUP),
        .T_INIT1  (T_INIT1),
        .T_INIT2  (T_INIT2),
        .T_CMD    (T_CMD),
        .T_NIB_GAP(T_NIB_GAP),
        .T_SETUP  (T_SETUP),
        .T_PULSE  (T_PULSE),
        .T_CLEAR  (T_CLEAR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .do_init       (do_init),
        .do_send_data  (do_send_data),
        .data_to_send  (data_to_send),
        .lcdrs_in      (lcdrs_in),
        .init_done     (init_done),
        .send_data_done(send_data_done),
        .lcde          (lcde),
        .lcdrs         (lcdrs),
        .lcdrw         (lcdrw),
        .lcddat        (lcddat)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the most recent rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         start;
        int         width;
        logic [3:0] dat;
        logic       rs;
        logic       clean;
    } pulse_t;

    typedef struct {
        int         at;
        logic [4:0] bus;
    } done_t;

    pulse_t obs_p[$], exp_p[$];
    done_t  obs_d[$], exp_d[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: records each lcde pulse, whether the bus was steady through setup and pulse,
    // and every cycle send_data_done is high.
    int init_rises = 0;
    int rw_bad = 0;
    initial begin
        pulse_t     cur;
        logic       e_prev, idone_prev;
        logic [4:0] bus, bus_h1, bus_h2;
        e_prev = 1'b0;
        idone_prev = 1'b0;
        bus_h1 = '0;
        bus_h2 = '0;
        cur = '{0, 0, 4'h0, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            bus = {lcdrs, lcddat};
            if (lcdrw !== 1'b0) rw_bad++;
            if (lcde === 1'b1 && !e_prev) begin
                cur = '{cyc, 1, lcddat, lcdrs, (bus_h1 === bus) && (bus_h2 === bus)};
            end else if (lcde === 1'b1) begin
                cur.width++;
                if (bus !== {cur.rs, cur.dat}) cur.clean = 1'b0;
            end else if (e_prev) begin
                obs_p.push_back(cur);
            end
            if (send_data_done === 1'b1) obs_d.push_back('{cyc, bus});
            if (init_done === 1'b1 && !idone_prev) init_rises++;
            e_prev = (lcde === 1'b1);
            idone_prev = (init_done === 1'b1);
            bus_h2 = bus_h1;
            bus_h1 = bus;
        end
    end

    // Reference model: a request sampled at edge e is accepted only when e >= ready_edge.
    int ready_edge = 0;
    bit inited = 1'b0;
    bit init_issued = 1'b0;
    int exp_init_rises = 0;

    task automatic model_reset();
        inited = 1'b0;
        init_issued = 1'b0;
    endtask

    task automatic model_init(input int e);
        int gaps[4];
        int t, rise;
        gaps = '{T_INIT1, T_INIT2, T_CMD, T_CMD};
        if (init_issued) return;
        init_issued = 1'b1;
        t = e + T_PWRUP;
        for (int k = 0; k < 4; k++) begin
            rise = t + T_SETUP;
            exp_p.push_back('{rise, T_PULSE, (k == 3) ? 4'h2 : 4'h3, 1'b0, 1'b1});
            t = rise + T_PULSE + gaps[k];
        end
        exp_init_rises++;
        inited = 1'b1;
        ready_edge = t + 1;
    endtask

    task automatic model_send(input int e, input logic [7:0] b, input logic rs);
        int tail, d;
        if (!inited || e < ready_edge) return;
        tail = T_CMD;
`ifdef LCD_CLEAR_WAIT_EN
        if (!rs && (b == 8'h01 || b == 8'h02)) tail = T_CLEAR;
`endif
        exp_p.push_back('{e + T_SETUP, T_PULSE, b[7:4], rs, 1'b1});
        exp_p.push_back('{e + 2 * T_SETUP + T_PULSE + T_NIB_GAP, T_PULSE, b[3:0], rs, 1'b1});
        d = e + 2 * T_SETUP + 2 * T_PULSE + T_NIB_GAP + tail;
        exp_d.push_back('{d, 5'h00});
        ready_edge = d + 1;
    endtask

    // All drivers start and end on a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req_init();
        do_init = 1'b1;
        model_init(cyc + 1);
        @(negedge clk);
        do_init = 1'b0;
    endtask

    task automatic req_send(input logic [7:0] b, input logic rs);
        do_send_data = 1'b1;
        data_to_send = b;
        lcdrs_in = rs;
        model_send(cyc + 1, b, rs);
        @(negedge clk);
        do_send_data = 1'b0;
        data_to_send = 8'($urandom);
        lcdrs_in = 1'($urandom);
    endtask

    task automatic req_both(input logic [7:0] b, input logic rs);
        do_init = 1'b1;
        do_send_data = 1'b1;
        data_to_send = b;
        lcdrs_in = rs;
        model_init(cyc + 1);
        model_send(cyc + 1, b, rs);
        @(negedge clk);
        do_init = 1'b0;
        do_send_data = 1'b0;
    endtask

    task automatic compare_flush(input string tag);
        check({tag, "_npulse"}, obs_p.size(), exp_p.size());
        for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
            check({tag, "_start"}, obs_p[i].start, exp_p[i].start);
            check({tag, "_width"}, obs_p[i].width, exp_p[i].width);
            check({tag, "_dat"}, obs_p[i].dat, exp_p[i].dat);
            check({tag, "_rs"}, obs_p[i].rs, exp_p[i].rs);
            check({tag, "_steady"}, obs_p[i].clean, exp_p[i].clean);
        end
        check({tag, "_ndone"}, obs_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            check({tag, "_done_at"}, obs_d[i].at, exp_d[i].at);
            check({tag, "_done_bus"}, obs_d[i].bus, exp_d[i].bus);
        end
        obs_p.delete();
        exp_p.delete();
        obs_d.delete();
        exp_d.delete();
    endtask

    initial begin
        pulse_t p;
        int     n;

        tick(2);
        check("rst_lcde", lcde, 0);
        check("rst_lcdrs", lcdrs, 0);
        check("rst_lcdrw", lcdrw, 0);
        check("rst_lcddat", lcddat, 0);
        check("rst_init_done", init_done, 0);
        check("rst_done", send_data_done, 0);
        reset = 1'b0;
        model_reset();

        // Byte before init, then init and send together: init wins, byte dropped.
        req_send(8'h55, 1'b1);
        tick(10);
        req_both(8'hAA, 1'b1);
        tick(80);
        check("init_done_hi", init_done, 1);
        compare_flush("init");

        // Second init is ignored; second byte arrives mid-byte and is dropped.
        req_init();
        tick(5);
        req_send(8'h48, 1'b1);
        tick(5);
        req_send(8'h66, 1'b0);
        tick(25);
        compare_flush("send48");

        req_send(8'h01, 1'b0);
        tick(40);
        req_send(8'h01, 1'b1);
        tick(30);
        req_send(8'h02, 1'b0);
        tick(40);
        compare_flush("clear");

        // Back-to-back: next request issued in the cycle send_data_done is seen.
        req_send(8'hC3, 1'b1);
        n = 0;
        while (send_data_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_wait", n < 100, 1);
        req_send(8'h3C, 1'b0);
        tick(40);
        compare_flush("b2b");

        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 2));
            tick($urandom_range(0, 24));
            req_send(b, 1'($urandom));
        end
        tick(60);
        compare_flush("rand");

        // Reset in the middle of the upper-nibble pulse truncates it.
        req_send(8'hA5, 1'b1);
        tick(T_SETUP + 1);
        check("pulse_before_rst", lcde, 1);
        reset = 1'b1;
        void'(exp_d.pop_back());
        void'(exp_p.pop_back());
        p = exp_p.pop_back();
        p.width = cyc + 1 - p.start;
        exp_p.push_back(p);
        model_reset();
        @(negedge clk);
        check("abort_lcde", lcde, 0);
        check("abort_init_done", init_done, 0);
        reset = 1'b0;
        req_send(8'h77, 1'b1);
        tick(40);
        check("idle_after_rst", init_done, 0);
        compare_flush("reset");

        req_init();
        tick(80);
        check("reinit_done", init_done, 1);
        req_send(8'h5A, 1'b0);
        tick(30);
        compare_flush("reinit");

        check("init_rises", init_rises, exp_init_rises);
        check("lcdrw_low", rw_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
